// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the external SRAM-like bus
// and the arbiter. The arbiter uses the master view; stages and memory use slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_done_o;
    logic              if_stallreq_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_done_o;
    logic              mem_stallreq_o;

    logic              bus_req_o;
    logic              bus_wr_o;
    logic [SEL_W-1:0]  bus_wstrb_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_addr_ok_i;
    logic              bus_data_ok_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport master (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_rdata_o, if_done_o, if_stallreq_o,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_done_o, mem_stallreq_o,
        output bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o, bus_wdata_o,
        input  bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );

    modport slave (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_rdata_o, if_done_o, if_stallreq_o,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_done_o, mem_stallreq_o,
        input  bus_req_o, bus_wr_o, bus_wstrb_o, bus_addr_o, bus_wdata_o,
        output bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store,
// one transaction at a time, MEM stage first.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus_if
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cancel_q    <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cancel_q    <= cancel_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cancel_d    = cancel_q;
        addr_d      = addr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        // A redirect only marks the fetch; the bus transaction itself runs to completion.
        if (bus_if.if_flush_i && (owner_q == OWN_IF) && (state_q != IDLE)) begin
            cancel_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus_if.mem_req_i) begin
                    state_d  = ADDR;
                    owner_d  = OWN_MEM;
                    cancel_d = 1'b0;
                    addr_d   = bus_if.mem_addr_i;
                    we_d     = bus_if.mem_we_i;
                    sel_d    = bus_if.mem_sel_i;
                    wdata_d  = bus_if.mem_wdata_i;
                end else if (bus_if.if_req_i && !bus_if.if_flush_i) begin
                    state_d  = ADDR;
                    owner_d  = OWN_IF;
                    cancel_d = 1'b0;
                    addr_d   = bus_if.if_addr_i;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    wdata_d  = '0;
                end
            end
            ADDR: begin
                if (bus_if.bus_addr_ok_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_if.bus_data_ok_i) begin
                    state_d = DONE;
                    // A flush arriving with the data already counts, so cancelled data never lands.
                    if (!we_q && (owner_q == OWN_MEM)) begin
                        mem_rdata_d = bus_if.bus_rdata_i;
                    end else if (!we_q && (owner_q == OWN_IF) && !cancel_d) begin
                        if_rdata_d = bus_if.bus_rdata_i;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.bus_req_o      = (state_q == ADDR);
    assign bus_if.bus_wr_o       = we_q;
    assign bus_if.bus_wstrb_o    = we_q ? sel_q : '0;
    assign bus_if.bus_addr_o     = addr_q;
    assign bus_if.bus_wdata_o    = wdata_q;

    assign bus_if.if_done_o      = (state_q == DONE) && (owner_q == OWN_IF) && !cancel_q;
    assign bus_if.mem_done_o     = (state_q == DONE) && (owner_q == OWN_MEM);
    assign bus_if.if_rdata_o     = if_rdata_q;
    assign bus_if.mem_rdata_o    = mem_rdata_q;

    assign bus_if.if_stallreq_o  = bus_if.if_req_i & ~bus_if.if_done_o;
    assign bus_if.mem_stallreq_o = bus_if.mem_req_i & ~bus_if.mem_done_o;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: random IF/MEM masters and a random bus
// slave, checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (busIf)
    );

    int checkCount = 0;
    int errorCount = 0;
    int cycle = 0;
    int dutDoneCount = 0;

    // Model of the one transaction in flight, described by the cycles it was granted and finished.
    bit                txActive, txAccepted, txDataSeen, txCancelled, txIsMem, txWe;
    int                txGrantCyc, txDoneCyc;
    logic [ADDR_W-1:0] txAddr;
    logic [SEL_W-1:0]  txSel;
    logic [DATA_W-1:0] txWdata;
    logic [DATA_W-1:0] ifExpData, lastMemData;

    bit                ifPending, memPending;
    logic [ADDR_W-1:0] ifAddrReg, memAddrReg;
    logic              memWeReg;
    logic [SEL_W-1:0]  memSelReg;
    logic [DATA_W-1:0] memWdataReg;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic logic [ADDR_W-1:0] randAddr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom);
        return a & ~ADDR_W'(3);
    endfunction

    // One clock cycle: drive masters and slave, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit doReset, input int ifRate, input int memRate,
                                 input int flushRate, input int okRate, input int spurRate);
        bit expBusReq, waitData, doneNow, expIfDone, expMemDone, canGrant, flushNow;
        @(posedge clk);
        #1;
        expBusReq  = txActive && !txAccepted && (cycle > txGrantCyc);
        waitData   = txActive && txAccepted && !txDataSeen;
        doneNow    = txActive && txDataSeen && (cycle == txDoneCyc);
        expIfDone  = doneNow && !txIsMem && !txCancelled;
        expMemDone = doneNow && txIsMem;
        canGrant   = !txActive;

        if (!ifPending && chance(ifRate)) begin
            ifPending = 1'b1;
            ifAddrReg = randAddr();
        end
        flushNow = !expIfDone && chance(flushRate);
        if (flushNow || !ifPending) ifAddrReg = randAddr();
        if (!memPending && chance(memRate)) begin
            memPending = 1'b1;
            memAddrReg  = randAddr();
            memWeReg    = 1'($urandom_range(1));
            memSelReg   = SEL_W'($urandom_range(15, 1));
            memWdataReg = DATA_W'($urandom);
        end else if (!memPending) begin
            memAddrReg  = randAddr();
            memWeReg    = 1'($urandom_range(1));
            memSelReg   = SEL_W'($urandom);
            memWdataReg = DATA_W'($urandom);
        end

        rst                  = doReset;
        busIf.if_req_i       = ifPending;
        busIf.if_addr_i      = ifAddrReg;
        busIf.if_flush_i     = flushNow;
        busIf.mem_req_i      = memPending;
        busIf.mem_addr_i     = memAddrReg;
        busIf.mem_we_i       = memWeReg;
        busIf.mem_sel_i      = memSelReg;
        busIf.mem_wdata_i    = memWdataReg;
        busIf.bus_addr_ok_i  = expBusReq ? chance(okRate) : chance(spurRate);
        busIf.bus_data_ok_i  = waitData ? chance(okRate) : chance(spurRate);
        busIf.bus_rdata_i    = DATA_W'($urandom);

        @(negedge clk);
        checkOutput("bus_req", 64'(busIf.bus_req_o), 64'(expBusReq));
        if (expBusReq) begin
            checkOutput("bus_addr", 64'(busIf.bus_addr_o), 64'(txAddr));
            checkOutput("bus_wr", 64'(busIf.bus_wr_o), 64'(txWe));
            checkOutput("bus_wstrb", 64'(busIf.bus_wstrb_o), 64'(txWe ? txSel : SEL_W'(0)));
            if (txWe) checkOutput("bus_wdata", 64'(busIf.bus_wdata_o), 64'(txWdata));
        end
        checkOutput("if_done", 64'(busIf.if_done_o), 64'(expIfDone));
        checkOutput("mem_done", 64'(busIf.mem_done_o), 64'(expMemDone));
        checkOutput("if_stallreq", 64'(busIf.if_stallreq_o), 64'(busIf.if_req_i & ~expIfDone));
        checkOutput("mem_stallreq", 64'(busIf.mem_stallreq_o), 64'(busIf.mem_req_i & ~expMemDone));
        if (expIfDone) checkOutput("if_rdata", 64'(busIf.if_rdata_o), 64'(ifExpData));
        checkOutput("mem_rdata", 64'(busIf.mem_rdata_o), 64'(lastMemData));
        if (busIf.if_done_o || busIf.mem_done_o) dutDoneCount++;

        if (doReset) begin
            txActive    = 1'b0;
            lastMemData = '0;
            ifPending   = 1'b0;
            memPending  = 1'b0;
        end else begin
            if (txActive && !txIsMem && (cycle > txGrantCyc) && !txDataSeen && flushNow) txCancelled = 1'b1;
            if (expBusReq && busIf.bus_addr_ok_i) begin
                txAccepted = 1'b1;
            end else if (waitData && busIf.bus_data_ok_i) begin
                txDataSeen = 1'b1;
                txDoneCyc  = cycle + 1;
                if (!txWe && txIsMem) lastMemData = busIf.bus_rdata_i;
                if (!txWe && !txIsMem && !txCancelled) ifExpData = busIf.bus_rdata_i;
            end
            if (doneNow) txActive = 1'b0;
            if (expIfDone) ifPending = 1'b0;
            if (expMemDone) memPending = 1'b0;
            if (canGrant && (memPending || (ifPending && !flushNow))) begin
                txActive    = 1'b1;
                txAccepted  = 1'b0;
                txDataSeen  = 1'b0;
                txCancelled = 1'b0;
                txGrantCyc  = cycle;
                txIsMem     = memPending;
                txAddr      = memPending ? memAddrReg : ifAddrReg;
                txWe        = memPending ? memWeReg : 1'b0;
                txSel       = memSelReg;
                txWdata     = memWdataReg;
            end
        end
        cycle++;
    endtask

    initial begin
        rst                 = 1'b1;
        busIf.if_req_i      = 1'b0;
        busIf.if_addr_i     = '0;
        busIf.if_flush_i    = 1'b0;
        busIf.mem_req_i     = 1'b0;
        busIf.mem_we_i      = 1'b0;
        busIf.mem_sel_i     = '0;
        busIf.mem_addr_i    = '0;
        busIf.mem_wdata_i   = '0;
        busIf.bus_addr_ok_i = 1'b0;
        busIf.bus_data_ok_i = 1'b0;
        busIf.bus_rdata_i   = '0;
        txActive    = 1'b0;
        ifExpData   = '0;
        lastMemData = '0;
        ifPending   = 1'b0;
        memPending  = 1'b0;
        ifAddrReg   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bus_req", 64'(busIf.bus_req_o), 64'd0);
        checkOutput("rst_bus_addr", 64'(busIf.bus_addr_o), 64'd0);
        checkOutput("rst_bus_wr", 64'(busIf.bus_wr_o), 64'd0);
        checkOutput("rst_bus_wstrb", 64'(busIf.bus_wstrb_o), 64'd0);
        checkOutput("rst_bus_wdata", 64'(busIf.bus_wdata_o), 64'd0);
        checkOutput("rst_if_done", 64'(busIf.if_done_o), 64'd0);
        checkOutput("rst_mem_done", 64'(busIf.mem_done_o), 64'd0);
        checkOutput("rst_if_rdata", 64'(busIf.if_rdata_o), 64'd0);
        checkOutput("rst_mem_rdata", 64'(busIf.mem_rdata_o), 64'd0);
        cycle = 0;

        $display("[TB] phase: IF only, immediate slave");
        for (int i = 0; i < 120; i++) applyStimulus(1'b0, 30, 0, 0, 100, 0);
        $display("[TB] phase: IF and MEM contention, immediate slave");
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 90, 60, 0, 100, 0);
        $display("[TB] phase: slow slave, spurious handshakes, flushes");
        for (int i = 0; i < 1500; i++) applyStimulus(1'b0, 60, 40, 6, 25, 10);
        $display("[TB] phase: random resets mid-operation");
        for (int i = 0; i < 1000; i++) applyStimulus(chance(2), 60, 40, 6, 30, 10);

        checkOutput("progress", 64'(dutDoneCount > 50), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
